biquad_mac_sequencer: RTL and testbench

Stereo biquad engine that time-shares one multiply-accumulate path across the five difference-equation terms and both channels.
- Triggered once per audio sample by a strobe.
- Fetches coefficients from an external coefficient ROM by tap index and manages the per-channel history.
- Applies filter-bank changes glitch-free at sample boundaries.
- Sits between the codec sample interface and the downstream channel-strip stages, running at clk_144.

---
 rtl/biquad_pkg.sv | 47 ++++
 rtl/biquad_coeff_rom.sv | 15 +
 rtl/biquad_mac_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_biquad_mac_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// Shared types, constants, coefficient banks and output saturation for the stereo biquad engine.
package biquad_pkg;

   localparam int W     = 64;
   localparam int SHIFT = 30;
   localparam int NTAP  = 5;
   localparam int NBANK = 4;

   typedef enum logic [2:0] {
      TAP_Y1 = 3'd0,
      TAP_Y2 = 3'd1,
      TAP_X0 = 3'd2,
      TAP_X1 = 3'd3,
      TAP_X2 = 3'd4
   } tap_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MAC    = 2'd1,
      ST_UPDATE = 2'd2
   } state_e;

   // Coefficients are authored in 1/256 steps and lifted to SHIFT fractional bits.
   function automatic logic signed [W-1:0] q8(input int n);
      logic signed [W-1:0] v;
      v = W'(n);
      return v <<< (SHIFT - 8);
   endfunction

   // Tap order y1, y2, x0, x1, x2; the y terms already carry the feedback sign.
   localparam logic signed [W-1:0] COEFF [NBANK][NTAP] = '{
      '{q8(508), q8(-253), q8(254), q8(-508), q8(254)},
      '{q8(504), q8(-249), q8(252), q8(-504), q8(252)},
      '{q8(496), q8(-242), q8(248), q8(-496), q8(248)},
      '{q8(480), q8(-228), q8(240), q8(-480), q8(240)}
   };

   localparam logic signed [W-1:0] SAT_HI = W'(32767);
   localparam logic signed [W-1:0] SAT_LO = W'(-32768);

   function automatic logic signed [15:0] saturate16(input logic signed [W-1:0] v);
      if (v > SAT_HI) return 16'sh7FFF;
      if (v < SAT_LO) return 16'sh8000;
      return v[15:0];
   endfunction

endpackage

// File: rtl/biquad_coeff_rom.sv
// Combinational coefficient lookup: (bank, tap index) -> signed coefficient, zero past the last tap.
module biquad_coeff_rom
   import biquad_pkg::*;
(
   input  logic [1:0]          bank_i,
   input  logic [2:0]          idx_i,
   output logic signed [W-1:0] coeff_o
);

   always_comb begin
      coeff_o = '0;
      if (idx_i < 3'(NTAP)) coeff_o = COEFF[bank_i][idx_i];
   end

endmodule

// File: rtl/biquad_mac_sequencer.sv
// Stereo biquad: one shared MAC walks 5 taps for L then R, saturates, rotates history.
// Result appears 11 edges after the accepting strobe; strobes while busy are dropped and flagged.
module biquad_mac_sequencer
   import biquad_pkg::*;
(
   input  logic                clk_144,
   input  logic                reset_n,
   input  logic                sample_valid,
   input  logic [2:0]          filter_sel,
   input  logic signed [15:0]  sample_in_l,
   input  logic signed [15:0]  sample_in_r,
   output logic [1:0]          coeff_bank,
   output logic [2:0]          coeff_idx,
   input  logic signed [W-1:0] coeff_data,
   output logic signed [15:0]  sample_out_l,
   output logic signed [15:0]  sample_out_r,
   output logic                out_valid,
   output logic                busy,
   output logic                overrun
);

   state_e              state_q, state_d;
   tap_e                tap_q, tap_d;
   logic                ch_q, ch_d;
   logic signed [W-1:0] acc_q, acc_d;
   logic signed [W-1:0] acc_l_q, acc_l_d;
   logic [2:0]          sel_q, sel_d;

   logic signed [15:0]  x0_q [2];
   logic signed [15:0]  x0_d [2];
   logic signed [15:0]  x1_q [2];
   logic signed [15:0]  x1_d [2];
   logic signed [15:0]  x2_q [2];
   logic signed [15:0]  x2_d [2];
   logic signed [15:0]  y1_q [2];
   logic signed [15:0]  y1_d [2];
   logic signed [15:0]  y2_q [2];
   logic signed [15:0]  y2_d [2];

   logic signed [15:0]  out_l_q, out_l_d;
   logic signed [15:0]  out_r_q, out_r_d;
   logic                out_valid_q, out_valid_d;
   logic                overrun_q, overrun_d;

   logic signed [15:0]    operand;
   logic signed [2*W-1:0] coeff_x, operand_x, product;
   logic signed [W-1:0]   term, acc_sum;
   logic signed [15:0]    y_sat [2];
   logic                  bypass;

   // Selects 4..7 pass the input straight through; the MAC still runs for identical timing.
   assign bypass = sel_q[2];

   always_comb begin : operand_mux
      operand = '0;
      unique case (tap_q)
         TAP_Y1:  operand = y1_q[ch_q];
         TAP_Y2:  operand = y2_q[ch_q];
         TAP_X0:  operand = x0_q[ch_q];
         TAP_X1:  operand = x1_q[ch_q];
         TAP_X2:  operand = x2_q[ch_q];
         default: operand = '0;
      endcase
   end

   assign coeff_x   = (2*W)'(coeff_data);
   assign operand_x = (2*W)'(operand);
   assign product   = coeff_x * operand_x;
   assign term      = W'(product >>> SHIFT);
   assign acc_sum   = bypass ? acc_q : acc_q + term;

   assign y_sat[0] = saturate16(acc_l_q);
   assign y_sat[1] = saturate16(acc_q);

   always_comb begin : next_state
      state_d     = state_q;
      tap_d       = tap_q;
      ch_d        = ch_q;
      acc_d       = acc_q;
      acc_l_d     = acc_l_q;
      sel_d       = sel_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      y1_d        = y1_q;
      y2_d        = y2_q;
      out_l_d     = out_l_q;
      out_r_d     = out_r_q;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               x0_d[0] = sample_in_l;
               x0_d[1] = sample_in_r;
               sel_d   = filter_sel;
               // New bank starts from silence so old state never rings through new coefficients.
               if (filter_sel != sel_q) begin
                  x1_d = '{default: '0};
                  x2_d = '{default: '0};
                  y1_d = '{default: '0};
                  y2_d = '{default: '0};
               end
               acc_d   = '0;
               tap_d   = TAP_Y1;
               ch_d    = 1'b0;
               state_d = ST_MAC;
            end
         end

         ST_MAC: begin
            overrun_d = sample_valid;
            if (tap_q == TAP_X2) begin
               tap_d = TAP_Y1;
               if (!ch_q) begin
                  acc_l_d = acc_sum;
                  acc_d   = '0;
                  ch_d    = 1'b1;
               end else begin
                  acc_d   = acc_sum;
                  state_d = ST_UPDATE;
               end
            end else begin
               tap_d = tap_e'(tap_q + 3'd1);
               acc_d = acc_sum;
            end
         end

         ST_UPDATE: begin
            overrun_d   = sample_valid;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
            if (bypass) begin
               out_l_d = x0_q[0];
               out_r_d = x0_q[1];
               x1_d    = '{default: '0};
               x2_d    = '{default: '0};
               y1_d    = '{default: '0};
               y2_d    = '{default: '0};
            end else begin
               out_l_d = y_sat[0];
               out_r_d = y_sat[1];
               // Feedback history keeps the clamped value that actually left the block.
               for (int c = 0; c < 2; c++) begin
                  x2_d[c] = x1_q[c];
                  x1_d[c] = x0_q[c];
                  y2_d[c] = y1_q[c];
                  y1_d[c] = y_sat[c];
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         tap_q       <= TAP_Y1;
         ch_q        <= 1'b0;
         acc_q       <= '0;
         acc_l_q     <= '0;
         sel_q       <= '0;
         x0_q        <= '{default: '0};
         x1_q        <= '{default: '0};
         x2_q        <= '{default: '0};
         y1_q        <= '{default: '0};
         y2_q        <= '{default: '0};
         out_l_q     <= '0;
         out_r_q     <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         acc_l_q     <= acc_l_d;
         sel_q       <= sel_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         y1_q        <= y1_d;
         y2_q        <= y2_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign coeff_bank   = sel_q[1:0];
   assign coeff_idx    = tap_q;
   assign sample_out_l = out_l_q;
   assign sample_out_r = out_r_q;
   assign out_valid    = out_valid_q;
   assign overrun      = overrun_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_biquad_mac_sequencer.sv
// Bench for the stereo biquad sequencer with the coefficient ROM alongside and a difference-equation model.
module tb_biquad_mac_sequencer;
   import biquad_pkg::*;

   logic                clk_144 = 1'b0;
   logic                reset_n = 1'b0;
   logic                sample_valid = 1'b0;
   logic [2:0]          filter_sel = '0;
   logic signed [15:0]  sample_in_l = '0;
   logic signed [15:0]  sample_in_r = '0;
   logic [1:0]          coeff_bank;
   logic [2:0]          coeff_idx;
   logic signed [W-1:0] coeff_data;
   logic signed [15:0]  sample_out_l, sample_out_r;
   logic                out_valid, busy, overrun;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_144 = ~clk_144;

   biquad_mac_sequencer dut (
      .clk_144(clk_144), .reset_n(reset_n), .sample_valid(sample_valid), .filter_sel(filter_sel),
      .sample_in_l(sample_in_l), .sample_in_r(sample_in_r), .coeff_bank(coeff_bank),
      .coeff_idx(coeff_idx), .coeff_data(coeff_data), .sample_out_l(sample_out_l),
      .sample_out_r(sample_out_r), .out_valid(out_valid), .busy(busy), .overrun(overrun)
   );

   biquad_coeff_rom u_rom (.bank_i(coeff_bank), .idx_i(coeff_idx), .coeff_o(coeff_data));

   // Reference model: y = sum floor(c*v / 2^30) per tap, clamp, shift history.
   longint             m_coef [4][5];
   logic signed [15:0] m_x1 [2];
   logic signed [15:0] m_x2 [2];
   logic signed [15:0] m_y1 [2];
   logic signed [15:0] m_y2 [2];
   logic [2:0]         m_sel;

   logic [2:0] idx_log  [10];
   logic [1:0] bank_log [10];
   logic       busy_acc, busy_vld;

   function automatic logic signed [15:0] clamp16(input longint v);
      if (v > 32767)  return 16'sd32767;
      if (v < -32768) return -16'sd32768;
      return 16'(v);
   endfunction

   task automatic model_clear_hist();
      for (int c = 0; c < 2; c++) begin
         m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
      end
   endtask

   task automatic model_reset();
      model_clear_hist();
      m_sel = 3'd0;
   endtask

   task automatic model_step(input logic signed [15:0] l, input logic signed [15:0] r,
                             input logic [2:0] sel,
                             output logic signed [15:0] el, output logic signed [15:0] er);
      logic signed [15:0] xin [2];
      logic signed [15:0] yo  [2];
      longint acc;
      int b;
      xin[0] = l;
      xin[1] = r;
      b = int'(sel[1:0]);
      if (sel != m_sel) model_clear_hist();
      m_sel = sel;
      for (int c = 0; c < 2; c++) begin
         if (sel[2]) yo[c] = xin[c];
         else begin
            acc = 0;
            acc += (m_coef[b][0] * longint'(m_y1[c])) >>> 30;
            acc += (m_coef[b][1] * longint'(m_y2[c])) >>> 30;
            acc += (m_coef[b][2] * longint'(xin[c])) >>> 30;
            acc += (m_coef[b][3] * longint'(m_x1[c])) >>> 30;
            acc += (m_coef[b][4] * longint'(m_x2[c])) >>> 30;
            yo[c] = clamp16(acc);
         end
      end
      if (sel[2]) model_clear_hist();
      else begin
         for (int c = 0; c < 2; c++) begin
            m_x2[c] = m_x1[c]; m_x1[c] = xin[c];
            m_y2[c] = m_y1[c]; m_y1[c] = yo[c];
         end
      end
      el = yo[0];
      er = yo[1];
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(negedge clk_144);
      reset_n = 1'b1;
      @(negedge clk_144);
      model_reset();
   endtask

   // Drives one strobe, scrambles inputs during the run, waits (bounded) for out_valid.
   task automatic do_sample(input logic signed [15:0] l, input logic signed [15:0] r,
                            input logic [2:0] sel,
                            output logic signed [15:0] gl, output logic signed [15:0] gr,
                            output int lat);
      @(negedge clk_144);
      sample_valid = 1'b1; sample_in_l = l; sample_in_r = r; filter_sel = sel;
      @(negedge clk_144);
      sample_valid = 1'b0;
      filter_sel   = 3'($urandom_range(0, 7));
      sample_in_l  = 16'($urandom);
      sample_in_r  = 16'($urandom);
      busy_acc = busy;
      busy_vld = 1'b1;
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         if (n <= 10) begin
            idx_log[n-1]  = coeff_idx;
            bank_log[n-1] = coeff_bank;
         end
         @(negedge clk_144);
         if (out_valid) begin
            lat = n;
            busy_vld = busy;
            break;
         end
      end
      gl = sample_out_l;
      gr = sample_out_r;
   endtask

   task automatic test_reset();
      int seen;
      reset_n = 1'b0;
      repeat (3) @(negedge clk_144);
      reset_n = 1'b1;
      @(negedge clk_144);
      n_checks++;
      if (sample_out_l !== 16'sd0 || sample_out_r !== 16'sd0) begin
         n_fail++; $display("FAIL reset_outputs: got %0d/%0d, expected 0/0", sample_out_l, sample_out_r);
      end
      n_checks++;
      if ({busy, overrun, out_valid} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: busy/overrun/out_valid got %b, expected 000", {busy, overrun, out_valid});
      end
      sample_valid = 1'b1; sample_in_l = 16'sd1000; sample_in_r = -16'sd1000; filter_sel = 3'd2;
      @(negedge clk_144);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk_144);
      n_checks++;
      if (busy !== 1'b1 || coeff_bank !== 2'd2) begin
         n_fail++; $display("FAIL reset_midmac_setup: busy=%b bank=%0d, expected busy=1 bank=2", busy, coeff_bank);
      end
      reset_n = 1'b0;
      @(negedge clk_144);
      reset_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk_144);
         if (out_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL reset_abort: out_valid pulses got %0d, expected 0", seen);
      end
      n_checks++;
      if (sample_out_l !== 16'sd0 || sample_out_r !== 16'sd0 || {busy, overrun} !== 2'b00 || coeff_bank !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_after_abort: out %0d/%0d busy=%b ovr=%b bank=%0d, expected 0/0 0 0 0",
                  sample_out_l, sample_out_r, busy, overrun, coeff_bank);
      end
      model_reset();
   endtask

   task automatic test_impulse();
      logic signed [15:0] gl, gr, el, er;
      int lat, bad;
      do_sample(16'sd16384, 16'sd0, 3'd0, gl, gr, lat);
      model_step(16'sd16384, 16'sd0, 3'd0, el, er);
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL impulse_latency: got %0d edges, expected 11", lat); end
      n_checks++;
      if (gl !== 16'sd16256 || gr !== 16'sd0) begin
         n_fail++; $display("FAIL impulse_first: got %0d/%0d, expected 16256/0", gl, gr);
      end
      n_checks++;
      if (gl !== el || gr !== er) begin
         n_fail++; $display("FAIL impulse_first_model: got %0d/%0d, expected %0d/%0d", gl, gr, el, er);
      end
      n_checks++;
      if (busy_acc !== 1'b1 || busy_vld !== 1'b0) begin
         n_fail++; $display("FAIL impulse_busy: after accept %b, at out_valid %b, expected 1 and 0", busy_acc, busy_vld);
      end
      bad = 0;
      for (int k = 0; k < 10; k++) if (idx_log[k] !== 3'(k % 5) || bank_log[k] !== 2'd0) bad++;
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL impulse_tap_sequence: got %0d wrong idx/bank cycles, expected 0", bad); end
      do_sample(16'sd0, 16'sd0, 3'd0, gl, gr, lat);
      model_step(16'sd0, 16'sd0, 3'd0, el, er);
      n_checks++;
      if (lat !== 11 || gl !== -16'sd254 || gr !== 16'sd0) begin
         n_fail++; $display("FAIL impulse_second: got %0d/%0d lat %0d, expected -254/0 lat 11", gl, gr, lat);
      end
      n_checks++;
      if (gl !== el || gr !== er) begin
         n_fail++; $display("FAIL impulse_second_model: got %0d/%0d, expected %0d/%0d", gl, gr, el, er);
      end
   endtask

   task automatic test_saturation();
      logic signed [15:0] gl, gr, el, er;
      int lat;
      pulse_reset();
      do_sample(-16'sd32768, 16'sd0, 3'd0, gl, gr, lat);
      model_step(-16'sd32768, 16'sd0, 3'd0, el, er);
      n_checks++;
      if (gl !== -16'sd32512 || gl !== el || gr !== er) begin
         n_fail++; $display("FAIL sat_first: got %0d/%0d, expected -32512/%0d", gl, gr, er);
      end
      do_sample(16'sd32767, 16'sd0, 3'd0, gl, gr, lat);
      model_step(16'sd32767, 16'sd0, 3'd0, el, er);
      n_checks++;
      if (gl !== 16'sd32767 || gl !== el || gr !== er) begin
         n_fail++; $display("FAIL sat_clamp: got %0d/%0d, expected 32767/%0d", gl, gr, er);
      end
      do_sample(16'sd0, 16'sd0, 3'd0, gl, gr, lat);
      model_step(16'sd0, 16'sd0, 3'd0, el, er);
      n_checks++;
      if (gl !== el || gr !== er) begin
         n_fail++; $display("FAIL sat_stored_y1: got %0d/%0d, expected %0d/%0d", gl, gr, el, er);
      end
   endtask

   task automatic test_bank_change();
      logic signed [15:0] gl, gr, el, er;
      int lat, bad;
      do_sample(16'sd0, 16'sd0, 3'd1, gl, gr, lat);
      model_step(16'sd0, 16'sd0, 3'd1, el, er);
      n_checks++;
      if (gl !== 16'sd0 || gr !== 16'sd0 || gl !== el || lat !== 11) begin
         n_fail++; $display("FAIL bank_change_clear: got %0d/%0d lat %0d, expected 0/0 lat 11", gl, gr, lat);
      end
      bad = 0;
      for (int k = 0; k < 10; k++) if (bank_log[k] !== 2'd1) bad++;
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL bank_change_rom_bank: got %0d cycles not on bank 1, expected 0", bad); end
   endtask

   task automatic test_overrun();
      logic signed [15:0] gl, gr, el, er;
      int ov_cnt, lat1, lat2, ov2;
      @(negedge clk_144);
      sample_valid = 1'b1; sample_in_l = 16'sd500; sample_in_r = -16'sd700; filter_sel = 3'd1;
      @(negedge clk_144);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk_144);
      sample_valid = 1'b1; sample_in_l = 16'sd9999; sample_in_r = -16'sd9999; filter_sel = 3'd3;
      @(negedge clk_144);
      sample_valid = 1'b0;
      n_checks++;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse: got %b, expected 1", overrun); end
      ov_cnt = (overrun === 1'b1) ? 1 : 0;
      lat1 = -1;
      for (int n = 6; n <= 30; n++) begin
         @(negedge clk_144);
         if (overrun) ov_cnt++;
         if (out_valid) begin lat1 = n; break; end
      end
      n_checks++;
      if (ov_cnt !== 1 || lat1 !== 11) begin
         n_fail++; $display("FAIL overrun_single: overruns %0d valid at %0d, expected 1 and 11", ov_cnt, lat1);
      end
      model_step(16'sd500, -16'sd700, 3'd1, el, er);
      n_checks++;
      if (sample_out_l !== el || sample_out_r !== er || coeff_bank !== 2'd1) begin
         n_fail++; $display("FAIL overrun_no_effect: got %0d/%0d bank %0d, expected %0d/%0d bank 1",
                             sample_out_l, sample_out_r, coeff_bank, el, er);
      end
      sample_valid = 1'b1; sample_in_l = -16'sd1500; sample_in_r = 16'sd2500; filter_sel = 3'd1;
      @(negedge clk_144);
      sample_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || overrun !== 1'b0) begin
         n_fail++; $display("FAIL overrun_concurrent_accept: busy=%b ovr=%b, expected 1/0", busy, overrun);
      end
      lat2 = -1; ov2 = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk_144);
         if (overrun) ov2++;
         if (out_valid) begin lat2 = n; break; end
      end
      gl = sample_out_l; gr = sample_out_r;
      model_step(-16'sd1500, 16'sd2500, 3'd1, el, er);
      n_checks++;
      if (lat2 !== 11 || ov2 !== 0 || gl !== el || gr !== er) begin
         n_fail++; $display("FAIL overrun_concurrent_result: got %0d/%0d lat %0d ovr %0d, expected %0d/%0d lat 11 ovr 0",
                             gl, gr, lat2, ov2, el, er);
      end
   endtask

   task automatic test_bypass();
      logic signed [15:0] gl, gr, el, er;
      int lat;
      do_sample(16'sd1234, -16'sd4321, 3'd5, gl, gr, lat);
      model_step(16'sd1234, -16'sd4321, 3'd5, el, er);
      n_checks++;
      if (gl !== 16'sd1234 || gr !== -16'sd4321 || lat !== 11) begin
         n_fail++; $display("FAIL bypass_pass: got %0d/%0d lat %0d, expected 1234/-4321 lat 11", gl, gr, lat);
      end
      do_sample(16'sd0, 16'sd0, 3'd0, gl, gr, lat);
      model_step(16'sd0, 16'sd0, 3'd0, el, er);
      n_checks++;
      if (gl !== 16'sd0 || gr !== 16'sd0 || gl !== el) begin
         n_fail++; $display("FAIL bypass_return: got %0d/%0d, expected 0/0", gl, gr);
      end
   endtask

   task automatic test_random();
      logic signed [15:0] l, r, gl, gr, el, er;
      logic [2:0] sel;
      int lat;
      sel = 3'd0;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
         l = 16'($urandom);
         r = 16'($urandom);
         if ($urandom_range(0, 1) == 1) begin l = l >>> 4; r = r >>> 4; end
         do_sample(l, r, sel, gl, gr, lat);
         model_step(l, r, sel, el, er);
         n_checks++;
         if (lat !== 11) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d, expected 11", i, lat); end
         n_checks++;
         if (gl !== el || gr !== er) begin
            n_fail++; $display("FAIL random_output[%0d] sel %0d: got %0d/%0d, expected %0d/%0d", i, sel, gl, gr, el, er);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk_144);
      end
   endtask

   initial begin
      for (int b = 0; b < 4; b++)
         for (int t = 0; t < 5; t++) m_coef[b][t] = longint'(COEFF[b][t]);
      model_reset();
      test_reset();
      test_impulse();
      test_saturation();
      test_bank_change();
      test_overrun();
      test_bypass();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
